ysyx_22041071_divider: RTL and testbench

Iterative radix-2 integer divider for the RV64M execute stage. It is the inverse-operation partner of the Wallace-tree multiplier and shares the same valid/ready handshake into the EXU. It covers DIV/DIVU/REM/REMU and the W variants. Each request yields both quotient and remainder, one quotient bit per cycle, with special cases resolved in a single cycle.

---
 rtl/ysyx_22041071_divider_pkg.sv | 6 +
 rtl/ysyx_22041071_div_step.sv | 16 +
 rtl/ysyx_22041071_divider.sv | 117 +++++++++++
 tb/tb_ysyx_22041071_divider.sv | 137 +++++++++++++
 4 files changed

// File: rtl/ysyx_22041071_divider_pkg.sv
// ysyx_22041071_divider_pkg: shared width constants and FSM encoding for the radix-2 divider
package ysyx_22041071_divider_pkg;
   localparam int DIV_XLEN = 64;
   localparam int WORD_W = 32;
   typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_e;
endpackage

// File: rtl/ysyx_22041071_div_step.sv
// ysyx_22041071_div_step: one restoring shift/subtract/select iteration over the partial remainder
module ysyx_22041071_div_step import ysyx_22041071_divider_pkg::*; #(
   parameter int XLEN = DIV_XLEN
) (
   input  logic [2*XLEN:0]  pr,
   input  logic [XLEN-1:0]  b,
   output logic [2*XLEN:0]  pr_next
);
   logic [2*XLEN:0] sh;
   logic [XLEN:0]   diff;
   always_comb begin
      sh = pr << 1;
      diff = sh[2*XLEN:XLEN] - {1'b0, b};
      pr_next = diff[XLEN] ? sh : {diff, sh[XLEN-1:1], 1'b1};
   end
endmodule

// File: rtl/ysyx_22041071_divider.sv
// ysyx_22041071_divider: iterative radix-2 DIV/DIVU/REM/REMU (+W) unit, one quotient bit per cycle
module ysyx_22041071_divider import ysyx_22041071_divider_pkg::*; #(
   parameter int XLEN = DIV_XLEN
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             div_valid,
   output logic             div_ready,
   input  logic             div_signed,
   input  logic             divw,
   input  logic [XLEN-1:0]  dividend,
   input  logic [XLEN-1:0]  divisor,
   input  logic             flush,
   output logic             out_valid,
   output logic [XLEN-1:0]  quotient,
   output logic [XLEN-1:0]  remainder
);
   localparam int PW = 2*XLEN+1;
   localparam int CW = $clog2(XLEN+1);
   div_state_e state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [PW-1:0] pr_q, pr_d, pr_step;
   logic [XLEN-1:0] b_q, b_d, quotient_q, quotient_d, remainder_q, remainder_d;
   logic q_neg_q, q_neg_d, r_neg_q, r_neg_d, word_q, word_d, out_valid_q, out_valid_d;
   logic [XLEN-1:0] a_ext, b_ext, a_abs, b_abs, min_neg, q_raw, r_raw;
   logic a_neg, b_neg, div_zero, special;

   function automatic logic [XLEN-1:0] wfix(input logic [XLEN-1:0] x, input logic w);
      return w ? {{(XLEN-WORD_W){x[WORD_W-1]}}, x[WORD_W-1:0]} : x;
   endfunction

   ysyx_22041071_div_step #(.XLEN(XLEN)) u_step (.pr(pr_q), .b(b_q), .pr_next(pr_step));

   assign a_ext = divw ? (div_signed ? wfix(dividend, 1'b1) : {{(XLEN-WORD_W){1'b0}}, dividend[WORD_W-1:0]}) : dividend;
   assign b_ext = divw ? (div_signed ? wfix(divisor, 1'b1) : {{(XLEN-WORD_W){1'b0}}, divisor[WORD_W-1:0]}) : divisor;
   assign a_neg = div_signed && a_ext[XLEN-1];
   assign b_neg = div_signed && b_ext[XLEN-1];
   assign a_abs = a_neg ? -a_ext : a_ext;
   assign b_abs = b_neg ? -b_ext : b_ext;
   assign min_neg = divw ? {{(XLEN-WORD_W+1){1'b1}}, {(WORD_W-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
   assign div_zero = b_ext == '0;
   assign special = div_zero || (div_signed && a_ext == min_neg && b_ext == {XLEN{1'b1}});
   assign q_raw = pr_step[XLEN-1:0];
   assign r_raw = pr_step[2*XLEN-1:XLEN];

   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      pr_d = pr_q;
      b_d = b_q;
      q_neg_d = q_neg_q;
      r_neg_d = r_neg_q;
      word_d = word_q;
      quotient_d = quotient_q;
      remainder_d = remainder_q;
      out_valid_d = 1'b0;
      if (flush) begin
         state_d = IDLE;
      end else if (state_q == IDLE && div_valid) begin
         word_d = divw;
         q_neg_d = a_neg ^ b_neg;
         r_neg_d = a_neg;
         b_d = b_abs;
         cnt_d = divw ? CW'(WORD_W) : CW'(XLEN);
         // word ops pre-align the dividend so 32 shifts leave quotient/remainder in place
         pr_d = {{(XLEN+1){1'b0}}, divw ? a_abs << WORD_W : a_abs};
         state_d = special ? DONE : BUSY;
         out_valid_d = special;
         if (special) begin
            quotient_d = wfix(div_zero ? {XLEN{1'b1}} : a_ext, divw);
            remainder_d = wfix(div_zero ? a_ext : '0, divw);
         end
      end else if (state_q == BUSY) begin
         pr_d = pr_step;
         cnt_d = cnt_q - CW'(1);
         if (cnt_q == CW'(1)) begin
            state_d = DONE;
            out_valid_d = 1'b1;
            quotient_d = wfix(q_neg_q ? -q_raw : q_raw, word_q);
            remainder_d = wfix(r_neg_q ? -r_raw : r_raw, word_q);
         end
      end else if (state_q == DONE) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q <= '0;
         pr_q <= '0;
         b_q <= '0;
         q_neg_q <= 1'b0;
         r_neg_q <= 1'b0;
         word_q <= 1'b0;
         quotient_q <= '0;
         remainder_q <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         pr_q <= pr_d;
         b_q <= b_d;
         q_neg_q <= q_neg_d;
         r_neg_q <= r_neg_d;
         word_q <= word_d;
         quotient_q <= quotient_d;
         remainder_q <= remainder_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign div_ready = state_q == IDLE;
   assign out_valid = out_valid_q && !flush;
   assign quotient = quotient_q;
   assign remainder = remainder_q;
endmodule

// File: tb/tb_ysyx_22041071_divider.sv
// tb_ysyx_22041071_divider: directed vectors with hand-computed results, cycle timing and abort behaviour
module tb_ysyx_22041071_divider;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        div_valid = 1'b0;
   logic        div_ready;
   logic        div_signed = 1'b0;
   logic        divw = 1'b0;
   logic [63:0] dividend = '0;
   logic [63:0] divisor = '0;
   logic        flush = 1'b0;
   logic        out_valid;
   logic [63:0] quotient;
   logic [63:0] remainder;
   int checks = 0;
   int errors = 0;

   ysyx_22041071_divider #(.XLEN(64)) dut (
      .clk(clk), .rst(rst), .div_valid(div_valid), .div_ready(div_ready),
      .div_signed(div_signed), .divw(divw), .dividend(dividend), .divisor(divisor),
      .flush(flush), .out_valid(out_valid), .quotient(quotient), .remainder(remainder)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // called just after a negedge; the request is accepted on the following posedge
   task automatic start(input string tag, input logic s, input logic w, input logic [63:0] a, input logic [63:0] b);
      chk({tag, ".ready_at_accept"}, {63'd0, div_ready}, 64'd1);
      div_valid = 1'b1;
      div_signed = s;
      divw = w;
      dividend = a;
      divisor = b;
      @(posedge clk);
      #1;
      div_valid = 1'b0;
      dividend = 64'hDEAD_BEEF_DEAD_BEEF;
      divisor = 64'h0;
   endtask

   task automatic run(input string tag, input logic s, input logic w, input logic [63:0] a, input logic [63:0] b,
                      input logic [63:0] eq, input logic [63:0] er, input int ecyc);
      int cyc;
      logic ready_low;
      start(tag, s, w, a, b);
      cyc = 0;
      ready_low = 1'b1;
      do begin
         @(negedge clk);
         cyc++;
         if (div_ready) ready_low = 1'b0;
      end while (!out_valid && cyc < 200);
      chk({tag, ".cycle"}, 64'(cyc), 64'(ecyc));
      chk({tag, ".quotient"}, quotient, eq);
      chk({tag, ".remainder"}, remainder, er);
      chk({tag, ".ready_low"}, {63'd0, ready_low}, 64'd1);
      @(negedge clk);
      chk({tag, ".ready_after"}, {63'd0, div_ready}, 64'd1);
      chk({tag, ".pulse_one_cycle"}, {63'd0, out_valid}, 64'd0);
   endtask

   initial begin
      int seen;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset.ready", {63'd0, div_ready}, 64'd1);
      chk("reset.out_valid", {63'd0, out_valid}, 64'd0);
      chk("reset.quotient", quotient, 64'd0);
      chk("reset.remainder", remainder, 64'd0);

      run("divu_100_7", 1'b0, 1'b0, 64'd100, 64'd7, 64'd14, 64'd2, 65);
      run("div_m7_2", 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 65);
      run("rem_7_m2", 1'b1, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 65);
      run("divu_big", 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd16, 64'h0FFF_FFFF_FFFF_FFFF, 64'd15, 65);
      run("div_by_zero", 1'b1, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 1);
      run("divuw_by_zero", 1'b0, 1'b1, 64'h1234_0000_8000_0000, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1);
      run("div_overflow", 1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'd0, 1);
      run("divw_overflow", 1'b1, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 64'd0, 1);
      run("divw_m7_2", 1'b1, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 33);
      run("divuw_8000_1", 1'b0, 1'b1, 64'h0000_0000_8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, 64'd0, 33);
      run("divuw_hi_ignored", 1'b0, 1'b1, 64'hABCD_0000_0000_0064, 64'h7777_0000_0000_0007, 64'd14, 64'd2, 33);

      // flush in cycle 10 of a 64-bit op
      start("flush", 1'b0, 1'b0, 64'd1000, 64'd3);
      repeat (10) @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      @(negedge clk);
      chk("flush.ready", {63'd0, div_ready}, 64'd1);
      chk("flush.out_valid", {63'd0, out_valid}, 64'd0);
      seen = 0;
      repeat (80) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      chk("flush.no_pulse", 64'(seen), 64'd0);

      // flush wins over a same-cycle request in IDLE
      div_valid = 1'b1;
      flush = 1'b1;
      dividend = 64'd5;
      divisor = 64'd0;
      @(posedge clk);
      #1;
      div_valid = 1'b0;
      flush = 1'b0;
      @(negedge clk);
      chk("flush_vs_valid.ready", {63'd0, div_ready}, 64'd1);
      chk("flush_vs_valid.out_valid", {63'd0, out_valid}, 64'd0);

      // reset in cycle 10 of a 64-bit op
      start("rst_abort", 1'b0, 1'b0, 64'd1000, 64'd3);
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_abort.ready", {63'd0, div_ready}, 64'd1);
      chk("rst_abort.out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_abort.quotient", quotient, 64'd0);
      chk("rst_abort.remainder", remainder, 64'd0);
      run("after_rst_9_3", 1'b1, 1'b0, 64'd9, 64'd3, 64'd3, 64'd0, 65);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
